// File: rtl/bp_me_mem_cmd_rr_arbiter.sv
// bp_me_mem_cmd_rr_arbiter
// Two-master merge stage in front of the L2 CCE-to-cache adapter. Port 0 (CCE)
// and port 1 (I/O/DMA) are arbitrated round-robin into one registered command
// stream. A source-tag FIFO records the winner of each grant, so in-order
// responses from the adapter can be steered back to the issuing port.
//
// Build option: define BP_ME_ARB_FIXED_PRIO_EN to make port 0 always win when
// both ports are valid. Without it the arbiter is round-robin.
module bp_me_mem_cmd_rr_arbiter #(
    parameter int msg_width_p   = 597,
    parameter int outstanding_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic [msg_width_p-1:0] cmd0_i,
    input  logic                   cmd0_v_i,
    output logic                   cmd0_ready_and_o,

    input  logic [msg_width_p-1:0] cmd1_i,
    input  logic                   cmd1_v_i,
    output logic                   cmd1_ready_and_o,

    output logic [msg_width_p-1:0] mem_cmd_o,
    output logic                   mem_cmd_v_o,
    input  logic                   mem_cmd_ready_and_i,

    input  logic [msg_width_p-1:0] mem_resp_i,
    input  logic                   mem_resp_v_i,
    output logic                   mem_resp_yumi_o,

    output logic [msg_width_p-1:0] resp0_o,
    output logic                   resp0_v_o,
    input  logic                   resp0_yumi_i,

    output logic [msg_width_p-1:0] resp1_o,
    output logic                   resp1_v_o,
    input  logic                   resp1_yumi_i
);

    // Tag FIFO geometry. Pointers need at least one bit even for depth 1.
    localparam int ptr_w = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
    localparam int cnt_w = $clog2(outstanding_p + 1);
    localparam logic [ptr_w-1:0] last_idx = ptr_w'(outstanding_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(outstanding_p);

    // Output register
    logic                   cmd_valid_r;
    logic [msg_width_p-1:0] cmd_data_r;

    // Arbitration state: 0 favours port 0, 1 favours port 1
    logic rr_ptr;

    // Tag FIFO
    logic             tag_mem [outstanding_p];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] tag_cnt;
    logic             tag_full;
    logic             tag_empty;
    logic             head;

    logic can_load;
    logic grant_ok;
    logic sel0;
    logic sel1;
    logic grant0;
    logic grant1;
    logic grant;
    logic pop;

    assign tag_full  = (tag_cnt == full_cnt);
    assign tag_empty = (tag_cnt == '0);
    assign head      = tag_mem[rd_ptr];

    // A full FIFO blocks grants even if a pop happens this cycle, so the push
    // path never waits on the response-side yumi.
    assign can_load = ~cmd_valid_r | mem_cmd_ready_and_i;
    assign grant_ok = can_load & ~tag_full;

    // Each port's selection looks only at the other port's valid, so a
    // port's ready never depends on its own valid.
`ifdef BP_ME_ARB_FIXED_PRIO_EN
    assign sel0 = 1'b1;
    assign sel1 = ~cmd0_v_i;
`else
    assign sel0 = ~cmd1_v_i | ~rr_ptr;
    assign sel1 = ~cmd0_v_i |  rr_ptr;
`endif

    assign cmd0_ready_and_o = grant_ok & sel0;
    assign cmd1_ready_and_o = grant_ok & sel1;
    assign grant0 = cmd0_v_i & cmd0_ready_and_o;
    assign grant1 = cmd1_v_i & cmd1_ready_and_o;
    assign grant  = grant0 | grant1;

    assign mem_cmd_v_o = cmd_valid_r;
    assign mem_cmd_o   = cmd_data_r;

    // Response steering: the FIFO head names the port owning this response.
    assign resp0_o         = mem_resp_i;
    assign resp1_o         = mem_resp_i;
    assign resp0_v_o       = mem_resp_v_i & ~tag_empty & ~head;
    assign resp1_v_o       = mem_resp_v_i & ~tag_empty &  head;
    assign mem_resp_yumi_o = (resp0_v_o & resp0_yumi_i) | (resp1_v_o & resp1_yumi_i);
    assign pop             = mem_resp_yumi_o;

    // Move priority to the losing port after every grant; hold otherwise.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= grant0;
        end
    end

    // Output register valid: set on grant, cleared when drained with no grant.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_valid_r <= 1'b0;
        end else if (grant) begin
            cmd_valid_r <= 1'b1;
        end else if (mem_cmd_ready_and_i) begin
            cmd_valid_r <= 1'b0;
        end
    end

    // Output register payload: capture the granted command unmodified.
    // NOTE: datapath and FIFO storage are not reset; valid bits and pointers
    // alone decide whether their contents are ever observed.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            cmd_data_r <= grant1 ? cmd1_i : cmd0_i;
        end
    end

    // Tag storage: record the source port of each grant.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_mem[wr_ptr] <= grant1;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap at the FIFO depth.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= (wr_ptr == last_idx) ? '0 : wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + ptr_w'(1);
            end
            case ({grant, pop})
                2'b10:   tag_cnt <= tag_cnt + cnt_w'(1);
                2'b01:   tag_cnt <= tag_cnt - cnt_w'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Flag a response that arrives while no command is outstanding.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_v_i && tag_empty))
            else $error("bp_me_mem_cmd_rr_arbiter: response with no outstanding command");
        end
    end

endmodule

// File: tb/tb_bp_me_mem_cmd_rr_arbiter.sv
// Directed testbench for bp_me_mem_cmd_rr_arbiter: reset, alternation,
// full tag FIFO, response steering with backpressure, output stall and
// asynchronous reset with commands in flight.
module tb_bp_me_mem_cmd_rr_arbiter;

    localparam int W = 597;
    localparam int D = 4;

`ifdef BP_ME_ARB_FIXED_PRIO_EN
    localparam logic fixed_prio = 1'b1;
`else
    localparam logic fixed_prio = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] cmd0;
    logic         cmd0_v;
    logic         cmd0_rdy;
    logic [W-1:0] cmd1;
    logic         cmd1_v;
    logic         cmd1_rdy;
    logic [W-1:0] mem_cmd;
    logic         mem_cmd_v;
    logic         mem_cmd_rdy;
    logic [W-1:0] mem_resp;
    logic         mem_resp_v;
    logic         mem_resp_yumi;
    logic [W-1:0] resp0;
    logic         resp0_v;
    logic         r0y;
    logic [W-1:0] resp1;
    logic         resp1_v;
    logic         r1y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bp_me_mem_cmd_rr_arbiter #(
        .msg_width_p  (W),
        .outstanding_p(D)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .cmd0_i             (cmd0),
        .cmd0_v_i           (cmd0_v),
        .cmd0_ready_and_o   (cmd0_rdy),
        .cmd1_i             (cmd1),
        .cmd1_v_i           (cmd1_v),
        .cmd1_ready_and_o   (cmd1_rdy),
        .mem_cmd_o          (mem_cmd),
        .mem_cmd_v_o        (mem_cmd_v),
        .mem_cmd_ready_and_i(mem_cmd_rdy),
        .mem_resp_i         (mem_resp),
        .mem_resp_v_i       (mem_resp_v),
        .mem_resp_yumi_o    (mem_resp_yumi),
        .resp0_o            (resp0),
        .resp0_v_o          (resp0_v),
        .resp0_yumi_i       (r0y),
        .resp1_o            (resp1),
        .resp1_v_o          (resp1_v),
        .resp1_yumi_i       (r1y)
    );

    // Distinctive payload: tag in the top byte, a scrambled tag mid-word, index low.
    function automatic logic [W-1:0] mk(input logic [7:0] tag, input logic [31:0] n);
        logic [W-1:0] v;
        v = '0;
        v[W-1 -: 8]  = tag;
        v[300 +: 8]  = tag ^ 8'h5A;
        v[31:0]      = n;
        return v;
    endfunction

    // Hand-derived grant order for two always-valid ports with six commands each.
    function automatic logic exp_port(input int i);
        if (fixed_prio) return (i >= 6);
        return i[0];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] exp_data;
        logic         ep;
        int           n0;
        int           n1;

        // Reset held with both ports requesting
        reset       = 1'b1;
        cmd0_v      = 1'b1;
        cmd1_v      = 1'b1;
        cmd0        = mk(8'hC0, 0);
        cmd1        = mk(8'h1F, 0);
        mem_cmd_rdy = 1'b0;
        mem_resp    = '0;
        mem_resp_v  = 1'b0;
        r0y         = 1'b0;
        r1y         = 1'b0;
        repeat (3) step();
        check_bit("reset_mem_cmd_v", mem_cmd_v, 1'b0);
        check_bit("reset_resp0_v", resp0_v, 1'b0);
        check_bit("reset_resp1_v", resp1_v, 1'b0);
        check_bit("reset_resp_yumi", mem_resp_yumi, 1'b0);

        // Alternation: first grant after reset is port 0, one command per
        // cycle, each response returned the cycle after its grant.
        reset       = 1'b0;
        mem_cmd_rdy = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 12; i++) begin
            cmd0_v = (n0 < 6);
            cmd1_v = (n1 < 6);
            cmd0   = mk(8'hC0, n0);
            cmd1   = mk(8'h1F, n1);
            if (i > 0) begin
                mem_resp_v = 1'b1;
                mem_resp   = mk(8'hE0, i - 1);
                r0y        = 1'b1;
                r1y        = 1'b1;
            end
            #1;
            ep = exp_port(i);
            check_bit("alt_xfer0", cmd0_v & cmd0_rdy, ~ep);
            check_bit("alt_xfer1", cmd1_v & cmd1_rdy, ep);
            if (i > 0) begin
                check_bit("alt_resp0_v", resp0_v, ~exp_port(i - 1));
                check_bit("alt_resp1_v", resp1_v, exp_port(i - 1));
                check_bit("alt_resp_yumi", mem_resp_yumi, 1'b1);
            end
            exp_data = ep ? mk(8'h1F, n1) : mk(8'hC0, n0);
            if (ep) n1++;
            else n0++;
            step();
            check_bit("alt_mem_cmd_v", mem_cmd_v, 1'b1);
            check_data("alt_mem_cmd", mem_cmd, exp_data);
        end
        cmd0_v   = 1'b0;
        cmd1_v   = 1'b0;
        mem_resp = mk(8'hE0, 11);
        #1;
        check_bit("alt_last_resp0_v", resp0_v, ~exp_port(11));
        check_bit("alt_last_resp1_v", resp1_v, exp_port(11));
        step();
        mem_resp_v = 1'b0;
        r0y        = 1'b0;
        r1y        = 1'b0;
        check_bit("alt_drain_mem_cmd_v", mem_cmd_v, 1'b0);

        // Full tag FIFO: four port-0 commands, no responses
        cmd0_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd0 = mk(8'hC0, 16 + k);
            #1;
            check_bit("full_fill_rdy0", cmd0_rdy, 1'b1);
            step();
        end
        cmd0 = mk(8'hC0, 20);
        #1;
        check_bit("full_5th_rdy0", cmd0_rdy, 1'b0);
        step();
        check_bit("full_held_rdy0", cmd0_rdy, 1'b0);
        check_bit("full_out_drained", mem_cmd_v, 1'b0);
        mem_resp_v = 1'b1;
        mem_resp   = mk(8'hE1, 0);
        r0y        = 1'b1;
        #1;
        check_bit("full_pop_yumi", mem_resp_yumi, 1'b1);
        check_bit("full_pop_cycle_rdy0", cmd0_rdy, 1'b0);
        step();
        mem_resp_v = 1'b0;
        #1;
        check_bit("full_after_pop_rdy0", cmd0_rdy, 1'b1);
        step();
        check_bit("full_5th_mem_cmd_v", mem_cmd_v, 1'b1);
        check_data("full_5th_mem_cmd", mem_cmd, mk(8'hC0, 20));
        cmd0_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_v = 1'b1;
            mem_resp   = mk(8'hE1, 1 + k);
            #1;
            check_bit("full_drain_resp0_v", resp0_v, 1'b1);
            check_bit("full_drain_resp1_v", resp1_v, 1'b0);
            step();
        end
        mem_resp_v = 1'b0;
        r0y        = 1'b0;
        check_bit("full_end_mem_cmd_v", mem_cmd_v, 1'b0);

        // Steering: issue port 1, port 0, port 1
        cmd1_v = 1'b1;
        cmd1   = mk(8'h1F, 30);
        #1;
        check_bit("steer_a_rdy1", cmd1_rdy, 1'b1);
        step();
        cmd1_v = 1'b0;
        cmd0_v = 1'b1;
        cmd0   = mk(8'hC0, 31);
        #1;
        check_bit("steer_b_rdy0", cmd0_rdy, 1'b1);
        step();
        cmd0_v = 1'b0;
        cmd1_v = 1'b1;
        cmd1   = mk(8'h1F, 32);
        #1;
        check_bit("steer_c_rdy1", cmd1_rdy, 1'b1);
        step();
        cmd1_v = 1'b0;
        // first response -> port 1
        mem_resp_v = 1'b1;
        mem_resp   = mk(8'hE2, 0);
        r1y        = 1'b1;
        #1;
        check_bit("steer_r0_resp1_v", resp1_v, 1'b1);
        check_bit("steer_r0_resp0_v", resp0_v, 1'b0);
        check_data("steer_r0_resp1_data", resp1, mk(8'hE2, 0));
        check_bit("steer_r0_yumi", mem_resp_yumi, 1'b1);
        step();
        // second response -> port 0, which stalls for three cycles
        mem_resp = mk(8'hE2, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_bit("steer_stall_resp0_v", resp0_v, 1'b1);
            check_bit("steer_stall_resp1_v", resp1_v, 1'b0);
            check_bit("steer_stall_yumi", mem_resp_yumi, 1'b0);
            step();
        end
        r0y = 1'b1;
        #1;
        check_data("steer_r1_resp0_data", resp0, mk(8'hE2, 1));
        check_bit("steer_r1_yumi", mem_resp_yumi, 1'b1);
        step();
        r0y      = 1'b0;
        mem_resp = mk(8'hE2, 2);
        #1;
        check_bit("steer_r2_resp1_v", resp1_v, 1'b1);
        check_bit("steer_r2_resp0_v", resp0_v, 1'b0);
        step();
        mem_resp_v = 1'b0;
        r1y        = 1'b0;

        // Output stall: adapter not ready for five cycles
        mem_cmd_rdy = 1'b0;
        cmd0_v      = 1'b1;
        cmd1_v      = 1'b1;
        cmd0        = mk(8'hC0, 40);
        cmd1        = mk(8'h1F, 40);
        #1;
        check_bit("stall_pre_rdy0", cmd0_rdy, 1'b1);
        check_bit("stall_pre_rdy1", cmd1_rdy, 1'b0);
        step();
        check_data("stall_load", mem_cmd, mk(8'hC0, 40));
        for (int k = 0; k < 5; k++) begin
            cmd0 = mk(8'hC0, 41 + k);
            cmd1 = mk(8'h1F, 41 + k);
            #1;
            check_bit("stall_rdy0", cmd0_rdy, 1'b0);
            check_bit("stall_rdy1", cmd1_rdy, 1'b0);
            check_bit("stall_mem_cmd_v", mem_cmd_v, 1'b1);
            check_data("stall_mem_cmd", mem_cmd, mk(8'hC0, 40));
            step();
        end
        cmd0        = mk(8'hC0, 50);
        cmd1        = mk(8'h1F, 50);
        mem_cmd_rdy = 1'b1;
        #1;
        // Pointer moved to port 1 at the pre-stall grant and held during the stall
        check_bit("stall_release_rdy0", cmd0_rdy, fixed_prio);
        check_bit("stall_release_rdy1", cmd1_rdy, ~fixed_prio);
        step();
        check_data("stall_release_mem_cmd", mem_cmd, fixed_prio ? mk(8'hC0, 50) : mk(8'h1F, 50));

        // Async reset with two tags outstanding and a command held
        cmd0_v      = 1'b0;
        cmd1_v      = 1'b0;
        mem_cmd_rdy = 1'b0;
        mem_resp_v  = 1'b1;
        mem_resp    = mk(8'hE3, 0);
        #1;
        check_bit("areset_pre_resp0_v", resp0_v, 1'b1);
        check_bit("areset_pre_mem_cmd_v", mem_cmd_v, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_bit("areset_mem_cmd_v", mem_cmd_v, 1'b0);
        check_bit("areset_resp0_v", resp0_v, 1'b0);
        check_bit("areset_resp1_v", resp1_v, 1'b0);
        mem_resp_v = 1'b0;
        step();
        step();
        reset       = 1'b0;
        mem_cmd_rdy = 1'b1;
        cmd0_v      = 1'b1;
        cmd1_v      = 1'b1;
        cmd0        = mk(8'hC0, 60);
        cmd1        = mk(8'h1F, 60);
        #1;
        check_bit("post_reset_mem_cmd_v", mem_cmd_v, 1'b0);
        check_bit("post_reset_rdy0", cmd0_rdy, 1'b1);
        check_bit("post_reset_rdy1", cmd1_rdy, 1'b0);
        step();
        check_data("post_reset_mem_cmd", mem_cmd, mk(8'hC0, 60));
        // An emptied FIFO accepts exactly four commands
        cmd1_v = 1'b0;
        for (int k = 1; k < 4; k++) begin
            cmd0 = mk(8'hC0, 60 + k);
            #1;
            check_bit("post_reset_fill_rdy0", cmd0_rdy, 1'b1);
            step();
        end
        cmd0 = mk(8'hC0, 64);
        #1;
        check_bit("post_reset_full_rdy0", cmd0_rdy, 1'b0);
        cmd0_v = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_me_mem_cmd_rr_arbiter.md
Name: bp_me_mem_cmd_rr_arbiter

Overview:
- Two-master merge stage directly upstream of the L2 CCE-to-cache adapter.
- Accepts BedRock mem commands from two sources (port 0 = CCE, port 1 = I/O/DMA), round-robin arbitrates them, and presents a single registered command stream to the adapter.
- The adapter returns responses in order, so an internal source-tag FIFO steers each response back to the port that issued the command.

Parameters:
- msg_width_p, 597, BedRock mem message width in bits (header plus block data); set from cce_mem_msg_width_lp.
- outstanding_p, 4, maximum commands in flight between grant and response yumi; this is the tag FIFO depth. Must be at least 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- cmd0_i  in  msg_width_p  port-0 command
- cmd0_v_i  in  1  port-0 command valid
- cmd0_ready_and_o  out  1  port-0 accept (ready-and handshake)
- cmd1_i  in  msg_width_p  port-1 command
- cmd1_v_i  in  1  port-1 command valid
- cmd1_ready_and_o  out  1  port-1 accept
- mem_cmd_o  out  msg_width_p  merged command to adapter
- mem_cmd_v_o  out  1  merged command valid
- mem_cmd_ready_and_i  in  1  adapter accept
- mem_resp_i  in  msg_width_p  response from adapter
- mem_resp_v_i  in  1  response valid
- mem_resp_yumi_o  out  1  response consumed
- resp0_o  out  msg_width_p  port-0 response (equals mem_resp_i)
- resp0_v_o  out  1  port-0 response valid
- resp0_yumi_i  in  1  port-0 consumes response
- resp1_o  out  msg_width_p  port-1 response (equals mem_resp_i)
- resp1_v_o  out  1  port-1 response valid
- resp1_yumi_i  in  1  port-1 consumes response

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - Output register empty, so mem_cmd_v_o=0.
  - Priority pointer = port 0.
  - Tag FIFO empty, so resp0_v_o=0, resp1_v_o=0, mem_resp_yumi_o=0.
  - mem_cmd_o data is don't-care.
  - A reset mid-transaction discards every in-flight tag; the adapter is reset in the same domain.
- Output register:
  - One entry holding {valid, data}.
  - can_load = ~valid | mem_cmd_ready_and_i.
  - Loads on grant; clears when the adapter accepts and there is no grant in the same cycle.
  - Load and drain in the same cycle is allowed, giving full throughput of one command per cycle.
- Grant conditions:
  - grant_ok = can_load & ~tag_full.
  - cmdN_ready_and_o = grant_ok & (port N selected by the arbiter).
  - Ready depends only on the other port's valid and on internal state, never on the same port's valid.
  - A transfer occurs when cmdN_v_i & cmdN_ready_and_o.
- Round-robin:
  - If exactly one port is valid, it is selected.
  - If both are valid, the port equal to the pointer is selected.
  - After each grant, the pointer moves to the non-granted port.
  - The pointer does not move without a grant.
- Command latency: granted command appears on mem_cmd_o the next cycle. The command is passed unmodified.
- Tag FIFO:
  - Depth outstanding_p, 1-bit entries (source port).
  - Pushed on grant; popped on mem_resp_yumi_o.
  - tag_full blocks grants even when a pop happens in the same cycle. This is a conservative choice that keeps the push path free of a combinational dependency on yumi.
  - Occupancy counter width = clog2(outstanding_p+1); read and write pointers wrap modulo outstanding_p.
- Response steering (combinational, zero latency):
  - head = FIFO head tag.
  - respN_v_o = mem_resp_v_i & ~tag_empty & (head==N).
  - mem_resp_yumi_o = the yumi of the selected port, gated with the same condition.
  - mem_resp_i with an empty FIFO: no response valid, no yumi, and a simulation $error fires (protocol violation).
- Backpressure:
  - A stalled response port blocks later responses to both ports; in-order delivery is required.
  - Commands keep flowing until tag_full.

Optional Feature:
- BP_ME_ARB_FIXED_PRIO_EN
- Defined: the pointer is ignored and port 0 always wins when both ports are valid. Port 1 is granted only when port 0 is not valid, which favours coherence traffic over I/O.
- Undefined: round-robin as specified above. All other behaviour is identical in both builds.

Test Plan:
- Reset:
  - Stimulus: hold reset_i=1 with both cmd valids high.
  - Required: mem_cmd_v_o=0 and resp*_v_o=0.
  - Stimulus: deassert reset.
  - Required: first grant goes to port 0; mem_cmd_o equals cmd0_i one cycle later.
- Alternation:
  - Stimulus: both ports continuously valid with 6 commands each, adapter ready=1, responses returned immediately.
  - Required: grant order 0,1,0,1,... (under FIXED_PRIO_EN, 6×port0 then 6×port1); one command per cycle.
- Full FIFO:
  - Stimulus: outstanding_p=4, port 0 issues 4 commands, no responses.
  - Required: 5th command ready=0.
  - Stimulus: in the cycle of the 1st response yumi.
  - Required: still ready=0; 5th command granted the following cycle.
- Steering:
  - Stimulus: issue port1, port0, port1.
  - Required: responses appear on resp1, resp0, resp1 in that order.
  - Stimulus: resp0_yumi_i held low for 3 cycles.
  - Required: resp1 for the third response is not presented until resp0 is consumed.
- Output stall:
  - Stimulus: mem_cmd_ready_and_i=0 for 5 cycles with mem_cmd_v_o=1.
  - Required: mem_cmd_o stable, both readies 0, pointer unchanged.
- Async reset mid-flight:
  - Stimulus: assert reset_i between clock edges with 2 tags outstanding.
  - Required: mem_cmd_v_o and resp*_v_o drop immediately; after release, FIFO empty and pointer = port 0.
